// File: rtl/uart_sim_transmitter.sv
// Simulation-side UART transmitter: byte FIFO feeding an LSB-first 8N1 serializer.
// Define UART_SIM_TX_PARITY_EN to add an even-parity bit (8E1 frames).
module uart_sim_transmitter #(
  parameter int BAUD_RATE  = 19200,
  parameter int CLOCK_FREQ = 100000000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] data_i,
  input  logic       valid_i,
  output logic       ready_o,
  output logic       txd_o,
  output logic       busy_o
);

  localparam int DIV = CLOCK_FREQ / BAUD_RATE;
  localparam int CW  = (DIV < 2) ? 1 : $clog2(DIV);
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(DIV - 1);

  if (DIV < 2) begin : g_div_check
    $error("uart_sim_transmitter: CLOCK_FREQ / BAUD_RATE must be at least 2");
  end

  if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_depth_check
    $error("uart_sim_transmitter: FIFO_DEPTH must be a power of two >= 2");
  end

`ifdef UART_SIM_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t          state, state_next;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [PW:0]     wr_ptr, rd_ptr;
  logic            full, empty, push, pop;
  logic [CW-1:0]   baud_cnt;
  logic [2:0]      bit_cnt;
  logic [7:0]      shreg, shreg_next;
  logic            baud_done, txd_next;
`ifdef UART_SIM_TX_PARITY_EN
  logic            parity;
`endif

  assign full      = (wr_ptr[PW] != rd_ptr[PW]) && (wr_ptr[PW-1:0] == rd_ptr[PW-1:0]);
  assign empty     = (wr_ptr == rd_ptr);
  assign ready_o   = !full;
  assign push      = valid_i && !full;
  assign busy_o    = (state != IDLE) || !empty;
  assign baud_done = (baud_cnt == BAUD_LAST);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr[PW-1:0]] <= data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_comb begin
    state_next = state;
    pop        = 1'b0;
    shreg_next = shreg;
    txd_next   = 1'b1;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop        = 1'b1;
          shreg_next = mem[rd_ptr[PW-1:0]];
          state_next = START;
        end
      end
      START: begin
        if (baud_done) state_next = DATA;
      end
      DATA: begin
        if (baud_done) begin
          shreg_next = {1'b0, shreg[7:1]};
          if (bit_cnt == 3'd7) begin
`ifdef UART_SIM_TX_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end
        end
      end
`ifdef UART_SIM_TX_PARITY_EN
      PARITY: begin
        if (baud_done) state_next = STOP;
      end
`endif
      STOP: begin
        if (baud_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    // txd_o is registered, so its next value follows the state being entered.
    case (state_next)
      START:   txd_next = 1'b0;
      DATA:    txd_next = shreg_next[0];
`ifdef UART_SIM_TX_PARITY_EN
      PARITY:  txd_next = parity;
`endif
      default: txd_next = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      txd_o    <= 1'b1;
`ifdef UART_SIM_TX_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      shreg <= shreg_next;
      txd_o <= txd_next;
      if (state == IDLE) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        baud_cnt <= baud_done ? '0 : baud_cnt + 1'b1;
        if ((state == DATA) && baud_done) bit_cnt <= bit_cnt + 1'b1;
      end
`ifdef UART_SIM_TX_PARITY_EN
      if (pop) parity <= ^shreg_next;
`endif
    end
  end

endmodule
